// File: rtl/checkers_pkg.sv
// Shared checkers board definitions: directions, board width, sequencer states
// and the square-neighbour rule used by the diagonal shift unit.
package checkers_pkg;

   localparam int BOARD_SQ = 32;

   localparam logic [1:0] DIR_UL = 2'd0;
   localparam logic [1:0] DIR_UR = 2'd1;
   localparam logic [1:0] DIR_DL = 2'd2;
   localparam logic [1:0] DIR_DR = 2'd3;

   localparam int MASK_UL_LO = 0;
   localparam int MASK_UR_LO = 32;
   localparam int MASK_DL_LO = 64;
   localparam int MASK_DR_LO = 96;

   typedef enum logic [1:0] {
      IDLE,
      SH1,
      SH2,
      DONE
   } state_t;

   function automatic int mask_lo(input logic [1:0] d);
      case (d)
         DIR_UL:  return MASK_UL_LO;
         DIR_UR:  return MASK_UR_LO;
         DIR_DL:  return MASK_DL_LO;
         default: return MASK_DR_LO;
      endcase
   endfunction

   // Returns {off_board, neighbour_square}; the square field is meaningless when off_board is set.
   function automatic logic [5:0] nbr_sq(input logic [4:0] p, input logic [1:0] d);
      logic [2:0] r;
      logic [1:0] c;
      logic       even;
      logic       ok;
      logic [4:0] n;
      r    = p[4:2];
      c    = p[1:0];
      even = ~r[0];
      case (d)
         DIR_UL: begin
            n  = even ? p - 5'd4 : p - 5'd5;
            ok = (r != 3'd0) && (even || (c != 2'd0));
         end
         DIR_UR: begin
            n  = even ? p - 5'd3 : p - 5'd4;
            ok = (r != 3'd0) && (!even || (c != 2'd3));
         end
         DIR_DL: begin
            n  = even ? p + 5'd4 : p + 5'd3;
            ok = (r != 3'd7) && (even || (c != 2'd0));
         end
         default: begin
            n  = even ? p + 5'd5 : p + 5'd4;
            ok = (r != 3'd7) && (!even || (c != 2'd3));
         end
      endcase
      return {~ok, n};
   endfunction

endpackage

// File: rtl/diag_shift.sv
// Combinational one-step diagonal shift: y[p] = x[neighbour_d(p)], off-board squares read as fill_i.
module diag_shift
   import checkers_pkg::*;
(
   input  logic [BOARD_SQ-1:0] x_i,
   input  logic [1:0]          dir_i,
   input  logic                fill_i,
   output logic [BOARD_SQ-1:0] y_o
);

   logic [5:0] nb;

   always_comb begin
      y_o = '0;
      nb  = '0;
      for (int p = 0; p < BOARD_SQ; p++) begin
         nb     = nbr_sq(5'(p), dir_i);
         y_o[p] = nb[5] ? fill_i : x_i[nb[4:0]];
      end
   end

endmodule

// File: rtl/move_gen_ctrl.sv
// Checkers move-generation sequencer: one shared diag_shift stepped over four directions.
// Define MOVEGEN_FORCE_JUMP_EN to suppress simple moves whenever a jump exists.
module move_gen_ctrl
   import checkers_pkg::*;
(
   input  logic         clock,
   input  logic         reset_n,
   input  logic         start,
   input  logic         side,
   input  logic [31:0]  own,
   input  logic [31:0]  opp,
   input  logic [31:0]  kings,
   output logic         busy,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] move_mask,
   output logic [127:0] jump_mask,
   output logic         any_move,
   output logic         any_jump
);

   state_t        state_q, state_d;
   logic [1:0]    dir_q, dir_d;
   logic [127:0]  move_q, move_d;
   logic [127:0]  jump_q, jump_d;
   logic [31:0]   own_q, opp_q, kown_q, nocc_q;
   logic          side_q;
   logic [31:0]   sh_x, sh_y, movers;
   logic          sh_fill, fwd;

   // The jump term is formed as nbr(opp & ~nbr(occ)) with fill 0, which equals
   // nbr(opp) & ~nbr(nbr(occ)) because the shift is a per-bit permutation.
   assign sh_x    = (state_q == SH2) ? (opp_q & ~nocc_q) : (own_q | opp_q);
   assign sh_fill = (state_q != SH2);

   diag_shift u_shift (
      .x_i    (sh_x),
      .dir_i  (dir_q),
      .fill_i (sh_fill),
      .y_o    (sh_y)
   );

   assign fwd    = side_q ? ((dir_q == DIR_UL) || (dir_q == DIR_UR))
                          : ((dir_q == DIR_DL) || (dir_q == DIR_DR));
   assign movers = (fwd ? (own_q & ~kown_q) : 32'd0) | kown_q;

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      move_d  = move_q;
      jump_d  = jump_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SH1;
               dir_d   = DIR_UL;
            end
         end
         SH1: state_d = SH2;
         SH2: begin
            move_d[mask_lo(dir_q) +: BOARD_SQ] = movers & ~nocc_q;
            jump_d[mask_lo(dir_q) +: BOARD_SQ] = movers & sh_y;
            if (dir_q == DIR_DR) begin
               state_d = DONE;
            end else begin
               state_d = SH1;
               dir_d   = dir_q + 2'd1;
            end
         end
         default: begin
            if (out_ready) begin
               state_d = IDLE;
               dir_d   = DIR_UL;
               move_d  = '0;
               jump_d  = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         dir_q   <= DIR_UL;
         move_q  <= '0;
         jump_q  <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         move_q  <= move_d;
         jump_q  <= jump_d;
      end
   end

   always_ff @(posedge clock) begin
      if ((state_q == IDLE) && start) begin
         own_q  <= own;
         opp_q  <= opp;
         kown_q <= kings & own;
         side_q <= side;
      end
      if (state_q == SH1) begin
         nocc_q <= sh_y;
      end
   end

   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign jump_mask = jump_q;
   assign any_jump  = |jump_q;

`ifdef MOVEGEN_FORCE_JUMP_EN
   assign move_mask = (out_valid && any_jump) ? 128'd0 : move_q;
`else
   assign move_mask = move_q;
`endif

   assign any_move = |move_mask;

endmodule

// File: tb/tb_move_gen_ctrl.sv
// Randomized and directed bench for move_gen_ctrl against a board-geometry reference model.
module tb_move_gen_ctrl;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         start;
   logic         side;
   logic [31:0]  own, opp, kings;
   logic         busy, out_valid, out_ready;
   logic [127:0] move_mask, jump_mask;
   logic         any_move, any_jump;

   int errors = 0;
   int checks = 0;

   move_gen_ctrl dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .side      (side),
      .own       (own),
      .opp       (opp),
      .kings     (kings),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .move_mask (move_mask),
      .jump_mask (jump_mask),
      .any_move  (any_move),
      .any_jump  (any_jump)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Neighbour on the 8x8 board: dark squares sit in odd columns on even rows.
   function automatic int nb(input int p, input int d);
      int r, col, nr, ncol;
      r    = p / 4;
      col  = (r % 2 == 0) ? 2 * (p % 4) + 1 : 2 * (p % 4);
      nr   = r + ((d < 2) ? -1 : 1);
      ncol = col + ((d == 0 || d == 2) ? -1 : 1);
      if (nr < 0 || nr > 7 || ncol < 0 || ncol > 7) return -1;
      return nr * 4 + ncol / 2;
   endfunction

   task automatic model(input logic [31:0] o, input logic [31:0] p, input logic [31:0] k,
                        input logic s, output logic [127:0] em, output logic [127:0] ej);
      logic [31:0] occ;
      int n, l;
      occ = o | p;
      em  = '0;
      ej  = '0;
      for (int d = 0; d < 4; d++) begin
         for (int q = 0; q < 32; q++) begin
            if (o[q] && (k[q] || (s ? (d < 2) : (d >= 2)))) begin
               n = nb(q, d);
               if (n >= 0) begin
                  if (!occ[n]) em[d*32+q] = 1'b1;
                  else if (p[n]) begin
                     l = nb(n, d);
                     if (l >= 0 && !occ[l]) ej[d*32+q] = 1'b1;
                  end
               end
            end
         end
      end
`ifdef MOVEGEN_FORCE_JUMP_EN
      if (ej != 0) em = '0;
`endif
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_move"}, move_mask, 0);
      chk({tag, "_jump"}, jump_mask, 0);
      chk({tag, "_anym"}, any_move, 0);
      chk({tag, "_anyj"}, any_jump, 0);
   endtask

   task automatic run_case(input logic [31:0] o, input logic [31:0] p, input logic [31:0] k,
                           input logic s, input int hold, input bit poke);
      logic [127:0] em, ej;
      int edges;
      @(negedge clock);
      own = o; opp = p; kings = k; side = s; start = 1'b1; out_ready = 1'b0;
      @(posedge clock); #1;
      start = 1'b0;
      own = $urandom; opp = $urandom; kings = $urandom; side = ~s;
      edges = 1;
      chk("busy_after_start", busy, 1);
      while (!out_valid && edges < 20) begin
         start = (poke && edges == 3);
         @(posedge clock); #1;
         edges++;
      end
      start = 1'b0;
      chk("latency_edges", edges, 9);
      model(o, p, k, s, em, ej);
      chk("move_mask", move_mask, em);
      chk("jump_mask", jump_mask, ej);
      chk("any_move", any_move, |em);
      chk("any_jump", any_jump, |ej);
      chk("busy_done", busy, 1);
      for (int i = 0; i < hold; i++) begin
         @(posedge clock); #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_move", move_mask, em);
         chk("hold_jump", jump_mask, ej);
      end
      out_ready = 1'b1;
      start = poke;
      @(posedge clock); #1;
      out_ready = 1'b0;
      start = 1'b0;
      chk("accept_busy", busy, 0);
      chk("accept_valid", out_valid, 0);
      chk("accept_move", move_mask, 0);
      chk("accept_jump", jump_mask, 0);
      @(posedge clock); #1;
      chk("idle_after_accept", busy, 0);
   endtask

   task automatic reset_mid_sequence();
      @(negedge clock);
      own = 32'h1 << 9; opp = 32'h1 << 14; kings = 32'h1 << 9; side = 1'b0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (5) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk_idle_outputs("midreset");
      @(negedge clock);
      reset_n = 1'b1;
      run_case(32'h1 << 9, 32'h1 << 14, 32'h0, 1'b0, 0, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; side = 1'b0; out_ready = 1'b0;
      own = '0; opp = '0; kings = '0;
      #2;
      chk_idle_outputs("reset");
      @(negedge clock);
      reset_n = 1'b1;

      run_case(32'h1 << 9,  32'h0,                          32'h0, 1'b0, 0, 1'b0);
      run_case(32'h1 << 11, 32'h0,                          32'h0, 1'b0, 0, 1'b0);
      run_case(32'h1 << 9,  32'h1 << 14,                    32'h0, 1'b0, 0, 1'b0);
      run_case(32'h1,       32'h0,                          32'h1, 1'b1, 0, 1'b0);
      run_case(32'h1 << 9,  (32'h1 << 14) | (32'h1 << 18),  32'h0, 1'b0, 0, 1'b1);
      reset_mid_sequence();
      run_case(32'h1 << 9,  32'h1 << 14,                    32'h0, 1'b0, 5, 1'b0);

      for (int t = 0; t < 24; t++) begin
         logic [31:0] ro, rp;
         ro = $urandom & $urandom;
         rp = $urandom & $urandom & ~ro;
         run_case(ro, rp, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
